// File: rtl/dfi_dram_responder.sv
// Controller-side DFI DRAM responder: decodes 4-phase commands, stores write bursts and returns
// read bursts after a fixed latency. Define DFI_RESP_ERRCHK_EN to enable the sticky error checker.
module dfi_dram_responder #(
    parameter int unsigned NPHASES = 4,
    parameter int unsigned ABITS   = 15,
    parameter int unsigned BABITS  = 3,
    parameter int unsigned DW      = 64,
    parameter int unsigned MEM_AW  = 10,
    parameter int unsigned RD_LAT  = 5,
    parameter int unsigned WR_LAT  = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NPHASES-1:0]        dfi_cs_n,
    input  logic [NPHASES-1:0]        dfi_ras_n,
    input  logic [NPHASES-1:0]        dfi_cas_n,
    input  logic [NPHASES-1:0]        dfi_we_n,
    input  logic [NPHASES*ABITS-1:0]  dfi_address,
    input  logic [NPHASES*BABITS-1:0] dfi_bank,
    input  logic [NPHASES-1:0]        dfi_wrdata_en,
    input  logic [NPHASES*DW-1:0]     dfi_wrdata,
    input  logic [NPHASES*DW/8-1:0]   dfi_wrdata_mask,
    output logic [NPHASES*DW-1:0]     dfi_rddata,
    output logic [NPHASES-1:0]        dfi_rddata_valid,
    output logic [3:0]                err_status,
    input  logic                      err_clear
);

    localparam int unsigned NBANKS    = 2 ** BABITS;
    localparam int unsigned BW        = NPHASES * DW;
    localparam int unsigned NBYTES    = BW / 8;
    localparam int unsigned KEYW      = BABITS + ABITS + 7;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b001;

    // XOR-fold {bank, row, col[9:3]} down to the storage index width
    function automatic logic [MEM_AW-1:0] mem_index(input logic [BABITS-1:0] b,
                                                    input logic [ABITS-1:0]  row,
                                                    input logic [6:0]        col);
        logic [KEYW-1:0]   key;
        logic [MEM_AW-1:0] idx;
        key = {b, row, col};
        idx = '0;
        for (int i = 0; i < KEYW; i++) begin
            idx[i % MEM_AW] ^= key[i];
        end
        return idx;
    endfunction

    logic [NBANKS-1:0] open_q, open_d;
    logic [ABITS-1:0]  row_q [NBANKS];
    logic [ABITS-1:0]  row_d [NBANKS];

    logic              rd_req, wr_req;
    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic              rd_exit_valid, wr_exit_valid;
    logic [MEM_AW-1:0] rd_exit_idx, wr_exit_idx;
    logic              wr_commit;

`ifdef DFI_RESP_ERRCHK_EN
    logic ev_closed, ev_state, ev_dup, ev_wrdata;
`endif

    always_comb begin
        logic [BABITS-1:0] b;
        logic [ABITS-1:0]  a;
        logic [2:0]        cmd;
        open_d = open_q;
        row_d  = row_q;
        rd_req = 1'b0;
        rd_idx = '0;
        wr_req = 1'b0;
        wr_idx = '0;
        b      = '0;
        a      = '0;
        cmd    = 3'b111;
`ifdef DFI_RESP_ERRCHK_EN
        ev_closed = 1'b0;
        ev_state  = 1'b0;
        ev_dup    = 1'b0;
`endif
        // Phases walk in order so later phases see bank updates from earlier ones
        for (int p = 0; p < NPHASES; p++) begin
            b   = dfi_bank[p*BABITS +: BABITS];
            a   = dfi_address[p*ABITS +: ABITS];
            cmd = {dfi_ras_n[p], dfi_cas_n[p], dfi_we_n[p]};
            if (!dfi_cs_n[p]) begin
                case (cmd)
                    CMD_ACT: begin
`ifdef DFI_RESP_ERRCHK_EN
                        if (open_d[b]) ev_state = 1'b1;
`endif
                        open_d[b] = 1'b1;
                        row_d[b]  = a;
                    end
                    CMD_PRE: begin
                        if (a[10]) open_d = '0;
                        else       open_d[b] = 1'b0;
                    end
                    CMD_RD: begin
`ifdef DFI_RESP_ERRCHK_EN
                        if (!open_d[b]) ev_closed = 1'b1;
                        if (rd_req)     ev_dup = 1'b1;
`endif
                        if (!rd_req) begin
                            rd_req = 1'b1;
                            rd_idx = mem_index(b, row_d[b], a[9:3]);
                        end
                    end
                    CMD_WR: begin
`ifdef DFI_RESP_ERRCHK_EN
                        if (!open_d[b]) ev_closed = 1'b1;
                        if (wr_req)     ev_dup = 1'b1;
`endif
                        if (!wr_req) begin
                            wr_req = 1'b1;
                            wr_idx = mem_index(b, row_d[b], a[9:3]);
                        end
                    end
                    CMD_REF: begin
`ifdef DFI_RESP_ERRCHK_EN
                        if (|open_d) ev_state = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            open_q <= '0;
            for (int i = 0; i < NBANKS; i++) row_q[i] <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    // The output register supplies the last cycle of read latency
    if (RD_LAT > 1) begin : g_rd_pipe
        localparam int unsigned D = RD_LAT - 1;
        logic [D-1:0]      vld_q;
        logic [MEM_AW-1:0] idx_q [D];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < D; i++) idx_q[i] <= '0;
            end else begin
                vld_q[0] <= rd_req;
                idx_q[0] <= rd_idx;
                for (int i = 1; i < D; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end

        assign rd_exit_valid = vld_q[D-1];
        assign rd_exit_idx   = idx_q[D-1];
    end else begin : g_rd_direct
        assign rd_exit_valid = rd_req;
        assign rd_exit_idx   = rd_idx;
    end

    logic [WR_LAT-1:0] wr_vld_q;
    logic [MEM_AW-1:0] wr_idx_q [WR_LAT];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_vld_q <= '0;
            for (int i = 0; i < WR_LAT; i++) wr_idx_q[i] <= '0;
        end else begin
            wr_vld_q[0] <= wr_req;
            wr_idx_q[0] <= wr_idx;
            for (int i = 1; i < WR_LAT; i++) begin
                wr_vld_q[i] <= wr_vld_q[i-1];
                wr_idx_q[i] <= wr_idx_q[i-1];
            end
        end
    end

    assign wr_exit_valid = wr_vld_q[WR_LAT-1];
    assign wr_exit_idx   = wr_idx_q[WR_LAT-1];
    assign wr_commit     = wr_exit_valid & (|dfi_wrdata_en);

    logic [BW-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (!dfi_wrdata_mask[i]) mem_q[wr_exit_idx][i*8 +: 8] <= dfi_wrdata[i*8 +: 8];
            end
        end
    end

    logic [BW-1:0] rddata_q;
    logic          rdvalid_q;

    // Read samples storage before a same-cycle commit lands, so it returns old data
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rdvalid_q <= rd_exit_valid;
            if (rd_exit_valid) rddata_q <= mem_q[rd_exit_idx];
        end
    end

    assign dfi_rddata       = rddata_q;
    assign dfi_rddata_valid = {NPHASES{rdvalid_q}};

`ifdef DFI_RESP_ERRCHK_EN
    logic [3:0] err_q;

    // Flags a WR commit without data as well as data without a commit
    assign ev_wrdata = wr_exit_valid ^ (|dfi_wrdata_en);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~{4{err_clear}}) | {ev_wrdata, ev_dup, ev_state, ev_closed};
        end
    end

    assign err_status = err_q;
`else
    assign err_status = '0;
`endif

endmodule
